// File: rtl/card_disp_pkg.sv
// Shared card codes, active-low 7-segment glyphs and FSM state type for the
// card display controller.
package card_disp_pkg;

  // Card codes as delivered by the datapath
  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_TWO   = 4'd2;
  localparam logic [3:0] CARD_THREE = 4'd3;
  localparam logic [3:0] CARD_FOUR  = 4'd4;
  localparam logic [3:0] CARD_FIVE  = 4'd5;
  localparam logic [3:0] CARD_SIX   = 4'd6;
  localparam logic [3:0] CARD_SEVEN = 4'd7;
  localparam logic [3:0] CARD_EIGHT = 4'd8;
  localparam logic [3:0] CARD_NINE  = 4'd9;
  localparam logic [3:0] CARD_TEN   = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_TEN   = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

  // Controller FSM states
  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } state_t;

  // Codes 0, 14 and 15 all mean "no card in this slot"
  function automatic logic card_is_empty(input logic [3:0] card);
    return (card == CARD_EMPTY) || (card > CARD_KING);
  endfunction

endpackage

// File: rtl/card_seg_decode.sv
// Combinational per-digit decoder: card code plus hide/blink state to an
// active-low 7-segment glyph.
module card_seg_decode
  import card_disp_pkg::*;
(
  input  logic [3:0] card,
  input  logic       hide,
  input  logic       blank_phase,
  output logic [6:0] glyph
);

  // Priority: empty, blink blank phase, face-down dash, card glyph
  always_comb begin
    glyph = SEG_BLANK;
    if (card_is_empty(card)) begin
      glyph = SEG_BLANK;
    end else if (blank_phase) begin
      glyph = SEG_BLANK;
    end else if (hide) begin
      glyph = SEG_DASH;
    end else begin
      case (card)
        CARD_ACE:   glyph = SEG_ACE;
        CARD_TWO:   glyph = SEG_TWO;
        CARD_THREE: glyph = SEG_THREE;
        CARD_FOUR:  glyph = SEG_FOUR;
        CARD_FIVE:  glyph = SEG_FIVE;
        CARD_SIX:   glyph = SEG_SIX;
        CARD_SEVEN: glyph = SEG_SEVEN;
        CARD_EIGHT: glyph = SEG_EIGHT;
        CARD_NINE:  glyph = SEG_NINE;
        CARD_TEN:   glyph = SEG_TEN;
        CARD_JACK:  glyph = SEG_JACK;
        CARD_QUEEN: glyph = SEG_QUEEN;
        CARD_KING:  glyph = SEG_KING;
        default:    glyph = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/card_display_ctrl.sv
// Multi-channel card display controller: holds NUM_CH card codes loaded via a
// valid/ready port, blinks newly loaded cards, supports a face-down mask and a
// clear sweep, and drives one registered 7-segment digit per channel.
module card_display_ctrl
  import card_disp_pkg::*;
#(
  parameter int NUM_CH      = 6,
  parameter int PRESCALE    = 25000000,
  parameter int BLINK_TICKS = 6,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ld_valid,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ld_ch,
  input  logic [3:0]                             ld_card,
  output logic                                   ld_ready,
  input  logic                                   clr,
  input  logic [NUM_CH-1:0]                      hide,
  output logic                                   busy,
  output logic [7*NUM_CH-1:0]                    seg7
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PS_W = $clog2(PRESCALE);
  localparam int BL_W = (BLINK_TICKS > 0) ? $clog2(BLINK_TICKS + 1) : 1;

  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BLINK_INIT = BL_W'(BLINK_TICKS);
  localparam logic [6:0]      BLANK_OUT  = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;

  state_t          state;
  logic [CH_W-1:0] idx;
  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic            accept;

  logic [3:0]      card  [NUM_CH];
  logic [BL_W-1:0] blink [NUM_CH];
  logic [6:0]      glyph [NUM_CH];

  assign tick   = (ps_cnt == PS_LAST);
  assign accept = ld_valid && ld_ready;

  // Control FSM with registered ld_ready/busy; clr is ignored mid-sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      ld_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ld_ready <= 1'b1;
          busy     <= 1'b0;
          if (clr) begin
            state    <= CLEAR;
            idx      <= '0;
            ld_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == LAST_CH) begin
            state    <= IDLE;
            ld_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Free-running blink prescaler, independent of loads and clears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Card and blink storage: sweep clear, then load, then tick decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        card[i]  <= '0;
        blink[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if ((state == CLEAR) && (idx == CH_W'(i))) begin
          card[i]  <= '0;
          blink[i] <= '0;
        end else if (accept && (ld_ch == CH_W'(i))) begin
          card[i]  <= ld_card;
          blink[i] <= BLINK_INIT;
        end else if (tick && (blink[i] != '0)) begin
          blink[i] <= blink[i] - 1'b1;
        end
      end
    end
  end

  // One glyph decoder per channel; odd blink counts are the blank phase
  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    card_seg_decode u_dec (
      .card       (card[g]),
      .hide       (hide[g]),
      .blank_phase(blink[g][0]),
      .glyph      (glyph[g])
    );
  end

  // Registered segment outputs with board polarity applied
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg7 <= {NUM_CH{BLANK_OUT}};
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        seg7[7*i +: 7] <= (ACTIVE_LOW != 0) ? glyph[i] : ~glyph[i];
      end
    end
  end

endmodule

// File: tb/tb_card_display_ctrl.sv
// Directed self-checking bench for card_display_ctrl (NUM_CH=4, PRESCALE=4,
// BLINK_TICKS=2, ACTIVE_LOW=1) plus a NUM_CH=3 instance for out-of-range loads.
module tb_card_display_ctrl;

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic [1:0]  ld_ch;
  logic [3:0]  ld_card;
  logic        ld_ready;
  logic        clr;
  logic [3:0]  hide;
  logic        busy;
  logic [27:0] seg7;

  logic        ld_valid3;
  logic [1:0]  ld_ch3;
  logic [3:0]  ld_card3;
  logic        ld_ready3;
  logic        clr3;
  logic [2:0]  hide3;
  logic        busy3;
  logic [20:0] seg7_3;

  int passed;
  int failed;
  int total;
  int cyc;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] G_A = 7'b0001000;
  localparam logic [6:0] G_2 = 7'b0100100;
  localparam logic [6:0] G_3 = 7'b0110000;
  localparam logic [6:0] G_4 = 7'b0011001;
  localparam logic [6:0] G_5 = 7'b0010010;
  localparam logic [6:0] G_8 = 7'b0000000;
  localparam logic [6:0] G_9 = 7'b0010000;
  localparam logic [6:0] G_J = 7'b1100001;
  localparam logic [6:0] G_Q = 7'b0011000;
  localparam logic [6:0] G_K = 7'b0001001;

  logic [6:0] glyph_tab [16];

  card_display_ctrl #(
    .NUM_CH(4), .PRESCALE(4), .BLINK_TICKS(2), .ACTIVE_LOW(1)
  ) u_dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ch(ld_ch),
    .ld_card(ld_card), .ld_ready(ld_ready), .clr(clr), .hide(hide),
    .busy(busy), .seg7(seg7)
  );

  card_display_ctrl #(
    .NUM_CH(3), .PRESCALE(4), .BLINK_TICKS(2), .ACTIVE_LOW(1)
  ) u_dut3 (
    .clk(clk), .reset(reset), .ld_valid(ld_valid3), .ld_ch(ld_ch3),
    .ld_card(ld_card3), .ld_ready(ld_ready3), .clr(clr3), .hide(hide3),
    .busy(busy3), .seg7(seg7_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the prescaler ticks on edges where cyc%4==0
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < 8; i++) if ((cyc % 4) != phase) step();
  endtask

  task automatic load(input logic [1:0] ch, input logic [3:0] code);
    ld_valid = 1'b1;
    ld_ch    = ch;
    ld_card  = code;
    step();
    ld_valid = 1'b0;
  endtask

  function automatic logic [6:0] dig(input int i);
    return seg7[7*i +: 7];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    glyph_tab = '{BL, G_A, G_2, G_3, G_4, G_5, 7'b0000010, 7'b1111000,
                  G_8, G_9, 7'b1000000, G_J, G_Q, G_K, BL, BL};
    reset = 1'b1; ld_valid = 1'b0; ld_ch = '0; ld_card = '0; clr = 1'b0; hide = '0;
    ld_valid3 = 1'b0; ld_ch3 = '0; ld_card3 = '0; clr3 = 1'b0; hide3 = '0;
    steps(2);
    check("rst_seg", {4'b0, seg7}, 32'h0FFFFFFF);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_ready", {31'b0, ld_ready}, 0);
    check("rst_seg3", {11'b0, seg7_3}, 32'h001FFFFF);
    reset = 1'b0;
    check("ready_before_edge", {31'b0, ld_ready}, 0);
    step();
    check("ready_after_release", {31'b0, ld_ready}, 1);

    // Reset during a clear sweep
    load(2'd0, 4'd1);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sweep_busy", {31'b0, busy}, 1);
    check("sweep_d0_shown", {25'b0, dig(0)}, {25'b0, G_A});
    reset = 1'b1;
    #1;
    check("async_rst_seg", {4'b0, seg7}, 32'h0FFFFFFF);
    check("async_rst_busy", {31'b0, busy}, 0);
    check("async_rst_ready", {31'b0, ld_ready}, 0);
    steps(3);
    reset = 1'b0;
    check("rel_ready_low", {31'b0, ld_ready}, 0);
    step();
    check("rel_ready_high", {31'b0, ld_ready}, 1);
    check("rel_busy", {31'b0, busy}, 0);
    check("rel_seg", {4'b0, seg7}, 32'h0FFFFFFF);

    // King on ch2, loaded just after a tick: ticks land at L+3 and L+7
    align(0);
    load(2'd2, 4'd13);
    step();
    check("k_l1", {25'b0, dig(2)}, {25'b0, G_K});
    steps(2);
    check("k_l3", {25'b0, dig(2)}, {25'b0, G_K});
    step();
    check("k_l4_blank", {25'b0, dig(2)}, {25'b0, BL});
    steps(3);
    check("k_l7_blank", {25'b0, dig(2)}, {25'b0, BL});
    step();
    check("k_l8", {25'b0, dig(2)}, {25'b0, G_K});
    steps(4);
    check("k_l12", {25'b0, dig(2)}, {25'b0, G_K});
    check("k_others_blank", {4'b0, seg7}, {4'b0, BL, G_K, BL, BL});

    // Face-down mask
    hide = 4'b0100;
    step();
    check("hide_dash", {25'b0, dig(2)}, {25'b0, DASH});
    hide = 4'b0000;
    step();
    check("unhide", {25'b0, dig(2)}, {25'b0, G_K});

    // Load on a tick edge: no decrement in that cycle
    align(3);
    load(2'd2, 4'd8);
    step();
    check("tickld_l1", {25'b0, dig(2)}, {25'b0, G_8});
    steps(3);
    check("tickld_l4", {25'b0, dig(2)}, {25'b0, G_8});
    step();
    check("tickld_l5_blank", {25'b0, dig(2)}, {25'b0, BL});

    // Every card code on ch0 after the blink has run out
    for (int c = 0; c < 16; c++) begin
      load(2'd0, 4'(c));
      steps(9);
      check($sformatf("code_%0d", c), {25'b0, dig(0)}, {25'b0, glyph_tab[c]});
    end

    // Clear sweep, with a held-off load and an ignored second clr
    load(2'd0, 4'd1);
    load(2'd1, 4'd2);
    load(2'd2, 4'd3);
    load(2'd3, 4'd4);
    steps(10);
    check("all_loaded", {4'b0, seg7}, {4'b0, G_4, G_3, G_2, G_A});
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sweep_busy_%0d", k), {31'b0, busy}, 1);
      check($sformatf("sweep_ready_%0d", k), {31'b0, ld_ready}, 0);
      if (k == 1) begin
        ld_valid = 1'b1; ld_ch = 2'd1; ld_card = 4'd9;
      end
      clr = (k == 2);
      step();
    end
    clr = 1'b0;
    check("sweep_done_busy", {31'b0, busy}, 0);
    check("sweep_done_ready", {31'b0, ld_ready}, 1);
    step();
    ld_valid = 1'b0;
    check("sweep_all_blank", {4'b0, seg7}, 32'h0FFFFFFF);
    step();
    check("held_load_shown", {4'b0, seg7}, {4'b0, BL, BL, G_9, BL});

    // clr and load to ch3 in the same cycle
    load(2'd3, 4'd5);
    steps(9);
    check("ch3_five", {25'b0, dig(3)}, {25'b0, G_5});
    clr = 1'b1; ld_valid = 1'b1; ld_ch = 2'd3; ld_card = 4'd7;
    step();
    clr = 1'b0; ld_valid = 1'b0;
    check("clr_ld_ready", {31'b0, ld_ready}, 0);
    steps(6);
    check("clr_ld_blank", {4'b0, seg7}, 32'h0FFFFFFF);
    check("clr_ld_busy", {31'b0, busy}, 0);

    // Back-to-back loads on ch1 with one idle cycle across a tick
    align(2);
    load(2'd1, 4'd12);
    step();
    check("b2b_q", {25'b0, dig(1)}, {25'b0, G_Q});
    load(2'd1, 4'd11);
    check("b2b_q_blank", {25'b0, dig(1)}, {25'b0, BL});
    step();
    check("b2b_j", {25'b0, dig(1)}, {25'b0, G_J});
    steps(2);
    check("b2b_j_l5", {25'b0, dig(1)}, {25'b0, G_J});
    step();
    check("b2b_blank_l6", {25'b0, dig(1)}, {25'b0, BL});
    steps(3);
    check("b2b_blank_l9", {25'b0, dig(1)}, {25'b0, BL});
    step();
    check("b2b_j_l10", {25'b0, dig(1)}, {25'b0, G_J});

    // Out-of-range channel on the 3-channel build
    ld_valid3 = 1'b1; ld_ch3 = 2'd0; ld_card3 = 4'd1;
    step();
    ld_valid3 = 1'b0;
    steps(9);
    check("n3_ace", {11'b0, seg7_3}, {11'b0, BL, BL, G_A});
    ld_valid3 = 1'b1; ld_ch3 = 2'd3; ld_card3 = 4'd13;
    check("n3_ready", {31'b0, ld_ready3}, 1);
    step();
    ld_valid3 = 1'b0;
    steps(9);
    check("n3_dropped", {11'b0, seg7_3}, {11'b0, BL, BL, G_A});
    check("n3_busy", {31'b0, busy3}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/card_display_ctrl.md
Name: card_display_ctrl

Overview:
Multi-channel successor to the single-digit card decoder: holds up to NUM_CH 4-bit card codes and drives one 7-segment digit per channel from registered outputs.
- Channels are loaded through a valid/ready write port.
- A newly loaded card blinks for a fixed number of prescaled ticks.
- A per-channel face-down mask shows a dash instead of the value.
- A clear command sweeps all channels back to empty.
- Sits between the baccarat datapath (card loads) and the board HEX displays.

Parameters:
NUM_CH, 6, number of card channels / digits (1..16)
PRESCALE, 25000000, clk cycles per blink tick (>=2)
BLINK_TICKS, 6, tick half-periods a new card blinks; must be even, 0 disables blinking
ACTIVE_LOW, 1, 1 = segment lit by 0 (board HEX), 0 = lit by 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ld_valid  in  1  load request
ld_ch  in  $clog2(NUM_CH) (min 1)  target channel
ld_card  in  4  card code: 0 empty, 1 A, 2-9, 10 shows "0", 11 J, 12 Q, 13 K, 14/15 empty
ld_ready  out  1  load accepted when ld_valid && ld_ready at rising clk
clr  in  1  single-cycle pulse: start clear sweep
hide  in  NUM_CH  per-channel face-down mask
busy  out  1  clear sweep in progress
seg7  out  7*NUM_CH  channel i at seg7[7i+6:7i], bit 0 = segment a

Behaviour:
Reset (asynchronous):
- all card registers 0, all blink counters 0, prescaler 0, FSM IDLE.
- busy 0; ld_ready 0 while reset is asserted, 1 from the first edge after release.
- every seg7 digit blank: 7'h7F if ACTIVE_LOW, else 7'h00.

FSM states:
- IDLE: ld_ready=1, busy=0. clr=1 -> CLEAR with sweep index 0.
- CLEAR: ld_ready=0, busy=1. Each cycle zeros card[idx] and blink[idx], then idx++. After idx=NUM_CH-1 -> IDLE. Sweep takes exactly NUM_CH cycles.
- clr while in CLEAR: ignored; the sweep is not restarted.

Loads:
- Accepted on ld_valid && ld_ready: card[ld_ch] <= ld_card and blink[ld_ch] <= BLINK_TICKS.
- ld_ch >= NUM_CH: the load is accepted and dropped; no state changes.
- Load to a channel that is already blinking: card replaced, blink restarted.
- Load with ld_card 0/14/15: stored, and the digit shows blank.
- clr and accepted load in the same IDLE cycle: the load is written, then overwritten by the sweep. Net result: the channel ends at 0.

Prescaler and blinking:
- Prescaler is free-running 0..PRESCALE-1. tick=1 in the cycle where the count equals PRESCALE-1.
- Prescaler is unaffected by loads and clr.
- On tick, every nonzero blink counter decrements by 1.
- Blanking phase: while blink[i] is odd, digit i shows blank. Even counts (including 0) show the normal digit.
- A load coinciding with a tick on the same channel: the load value wins, no decrement that cycle.

Display priority per channel:
1. card empty (0/14/15) -> blank
2. else blink odd -> blank
3. else hide[i] -> dash (segment g only; 7'b0111111 when ACTIVE_LOW)
4. else decoded glyph

Glyphs (active-low form): A 0001000, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, 10 1000000, J 1100001, Q 0011000, K 0001001. If ACTIVE_LOW=0, outputs are inverted.

Latency:
- seg7 is registered: a state change at edge k appears on seg7 after edge k+1.
- hide is sampled at the same edge; a hide change is visible 1 cycle later.

Decomposition:
- Package card_disp_pkg:
  - card code localparams (CARD_EMPTY, CARD_ACE..CARD_KING)
  - 7-bit active-low glyph constants, including SEG_BLANK and SEG_DASH
  - FSM state enum {IDLE, CLEAR}
- Sub-module card_seg_decode: purely combinational (card, hide, blank_phase) -> active-low 7-bit glyph. Instantiated NUM_CH times in a generate loop.
- Top level owns the FSM, prescaler, blink counters, polarity inversion and output registers.

Test Plan (NUM_CH=4, PRESCALE=4, BLINK_TICKS=2, ACTIVE_LOW=1):
1. Reset mid-operation: assert reset for 3 cycles during a CLEAR sweep -> seg7=28'hFFFFFFF, busy=0 immediately; ld_ready=1 the cycle after release.
2. Load ch2 with 13: digit2=0001001 one cycle after acceptance; blank after the first tick; K again after the second tick; stays K afterwards.
3. hide=4'b0100 with ch2=K and blink done -> digit2=0111111. Clear hide -> digit2=0001001 one cycle later.
4. Card codes: load ch0 with each code 0-15, allowing blink to expire -> matches the glyph list; codes 0, 14, 15 give 1111111.
5. Clear sweep: load all channels, pulse clr -> busy=1 and ld_ready=0 for exactly 4 cycles; every digit then blank. A load offered during the sweep is held off and accepted the cycle after busy falls.
6. Edge cases:
   - clr and load to ch3 in the same cycle -> ch3 ends blank.
   - ld_ch=3 on NUM_CH=3 build -> accepted, no digit changes.
   - back-to-back loads to ch1 one cycle apart -> second card shown, blink restarted.
